// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, register-index helpers and writeback types for the regfile writeback path.
// Pure declarations; no timing or flow-control behaviour of its own.
package regfile_wb_arbiter_pkg;

  localparam int XPR_LEN        = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int NUM_REGS       = 2 ** REG_ADDR_WIDTH;
  localparam int STARVE_W       = 4;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_idx_t;
  typedef logic [XPR_LEN-1:0]        xpr_t;

  localparam reg_idx_t X0 = '0;

  // One registered write toward the register file.
  typedef struct packed {
    logic     en;
    reg_idx_t addr;
    xpr_t     data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LD   = 2'd2
  } gnt_e;

  function automatic logic is_x0(input reg_idx_t idx);
    return idx == X0;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load bit per register: set on load issue, cleared on load writeback; x0 never marked.
// Reads are combinational from current state (no bypass); updates land next cycle; never stalls.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t rd1_idx,
  input  reg_idx_t rd2_idx,
  input  reg_idx_t iss_idx,
  input  reg_idx_t alu_idx,
  output logic     rd1_busy,
  output logic     rd2_busy,
  output logic     iss_busy,
  output logic     alu_busy
);

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;

  // Set is applied after clear so a same-cycle reissue keeps the register outstanding.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) begin
      sb_d[clr_idx] = 1'b0;
    end
    if (set_en && !is_x0(set_idx)) begin
      sb_d[set_idx] = 1'b1;
    end
    sb_d[X0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign rd1_busy = sb_q[rd1_idx] && !is_x0(rd1_idx);
  assign rd2_busy = sb_q[rd2_idx] && !is_x0(rd2_idx);
  assign iss_busy = sb_q[iss_idx] && !is_x0(iss_idx);
  assign alu_busy = sb_q[alu_idx];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and load-return writebacks onto the single regfile write port; write lands 1 cycle after grant.
// Loser sees ready=0 and must hold; loads win by default, ALU forced through after STARVE_LIMIT lost cycles.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [XPR_LEN-1:0]        alu_data,
  input  logic                      ld_valid,
  output logic                      ld_ready,
  input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
  input  logic [XPR_LEN-1:0]        ld_data,
  input  logic                      ld_issue,
  input  logic [REG_ADDR_WIDTH-1:0] ld_issue_rd,
  output logic                      ld_issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
  output logic                      rs1_busy,
  output logic                      rs2_busy,
  output logic                      rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  output logic [XPR_LEN-1:0]        rf_write_data
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                alu_pending_load;
  logic                iss_busy;
  logic                alu_elig;
  logic                ld_elig;
  gnt_e                gnt_sel;
  logic                alu_gnt;
  logic                ld_gnt;
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  wb_req_t             wb_q;
  wb_req_t             wb_d;

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (ld_issue && ld_issue_ready),
    .set_idx  (ld_issue_rd),
    .clr_en   (ld_gnt),
    .clr_idx  (ld_rd),
    .rd1_idx  (rs1_addr),
    .rd2_idx  (rs2_addr),
    .iss_idx  (ld_issue_rd),
    .alu_idx  (alu_rd),
    .rd1_busy (rs1_busy),
    .rd2_busy (rs2_busy),
    .iss_busy (iss_busy),
    .alu_busy (alu_pending_load)
  );

  assign ld_issue_ready = !iss_busy;

  // An ALU result may not overtake an outstanding load to the same register.
  assign alu_elig = alu_valid && !alu_pending_load;
  assign ld_elig  = ld_valid;

  always_comb begin
    gnt_sel = GNT_NONE;
    if (alu_elig && (!ld_elig || (starve_q == STARVE_MAX))) begin
      gnt_sel = GNT_ALU;
    end else if (ld_elig) begin
      gnt_sel = GNT_LD;
    end
  end

  assign alu_gnt   = (gnt_sel == GNT_ALU);
  assign ld_gnt    = (gnt_sel == GNT_LD);
  assign alu_ready = alu_gnt;
  assign ld_ready  = ld_gnt;

  always_comb begin
    starve_d = '0;
    if (alu_elig && !alu_gnt) begin
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
    end
  end

  // Grants to x0 complete the handshake but never raise the write enable.
  always_comb begin
    wb_d      = wb_q;
    wb_d.en   = 1'b0;
    case (gnt_sel)
      GNT_ALU: begin
        wb_d.en   = !is_x0(alu_rd);
        wb_d.addr = alu_rd;
        wb_d.data = alu_data;
      end
      GNT_LD: begin
        wb_d.en   = !is_x0(ld_rd);
        wb_d.addr = ld_rd;
        wb_d.data = ld_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      wb_q     <= '0;
    end else begin
      starve_q <= starve_d;
      wb_q     <= wb_d;
    end
  end

  assign rf_write_en   = wb_q.en;
  assign rf_write_addr = wb_q.addr;
  assign rf_write_data = wb_q.data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a pending-load model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_valid, ld_valid, ld_issue;
  logic        alu_ready, ld_ready, ld_issue_ready, rs1_busy, rs2_busy, rf_write_en;
  logic [4:0]  alu_rd, ld_rd, ld_issue_rd, rs1_addr, rs2_addr, rf_write_addr;
  logic [31:0] alu_data, ld_data, rf_write_data;

  int pass_cnt = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    ld_issue = 1'b0; ld_issue_rd = '0;
    rs1_addr = '0; rs2_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    ld_issue = 1'b1; ld_issue_rd = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_1234;
    tick();
    idle_inputs();
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    #1;
    check_cnt++;
    if (rs1_busy !== 1'b1) $display("FAIL reset_pre_busy: got %b want 1", rs1_busy); else pass_cnt++;
    check_cnt++;
    if (rf_write_en !== 1'b1) $display("FAIL reset_pre_wen: got %b want 1", rf_write_en); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    check_cnt++;
    if (rf_write_en !== 1'b0) $display("FAIL reset_wen: got %b want 0", rf_write_en); else pass_cnt++;
    check_cnt++;
    if (rf_write_addr !== 5'd0) $display("FAIL reset_waddr: got %0d want 0", rf_write_addr); else pass_cnt++;
    check_cnt++;
    if (rf_write_data !== 32'd0) $display("FAIL reset_wdata: got %h want 0", rf_write_data); else pass_cnt++;
    check_cnt++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
      $display("FAIL reset_busy: got rs1=%b rs2=%b want 0 0", rs1_busy, rs2_busy);
    else pass_cnt++;
    for (int r = 0; r < 32; r++) begin
      ld_issue_rd = 5'(r);
      #1;
      check_cnt++;
      if (ld_issue_ready !== 1'b1) $display("FAIL reset_issue_ready rd=%0d: got %b want 1", r, ld_issue_ready);
      else pass_cnt++;
    end
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_only();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    #1;
    check_cnt++;
    if (alu_ready !== 1'b1 || ld_ready !== 1'b0)
      $display("FAIL alu_only_ready: got alu=%b ld=%b want 1 0", alu_ready, ld_ready);
    else pass_cnt++;
    tick();
    alu_valid = 1'b0;
    check_cnt++;
    if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd5 || rf_write_data !== 32'hDEAD_BEEF)
      $display("FAIL alu_only_write: got en=%b a=%0d d=%h want 1 5 deadbeef", rf_write_en, rf_write_addr, rf_write_data);
    else pass_cnt++;
    tick();
    check_cnt++;
    if (rf_write_en !== 1'b0 || rf_write_addr !== 5'd5 || rf_write_data !== 32'hDEAD_BEEF)
      $display("FAIL alu_only_hold: got en=%b a=%0d d=%h want 0 5 deadbeef", rf_write_en, rf_write_addr, rf_write_data);
    else pass_cnt++;
  endtask

  task automatic test_conflict();
    int  alu_n;
    int  ld_n;
    bit  exp_alu;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    alu_n = 0;
    ld_n = 0;
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      ld_issue = 1'b1; ld_issue_rd = 5'(11 + i);
      tick();
    end
    ld_issue = 1'b0;
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0000 + 32'(alu_n);
      ld_valid = 1'b1; ld_rd = 5'(11 + ld_n); ld_data = 32'hB000_0000 + 32'(ld_n);
      #1;
      exp_alu = ((c % 5) == 4);
      check_cnt++;
      if (alu_ready !== exp_alu || ld_ready !== !exp_alu)
        $display("FAIL conflict_ready c=%0d: got alu=%b ld=%b want %b %b", c, alu_ready, ld_ready, exp_alu, !exp_alu);
      else pass_cnt++;
      exp_addr = exp_alu ? 5'd1 : 5'(11 + ld_n);
      exp_data = exp_alu ? 32'hA000_0000 + 32'(alu_n) : 32'hB000_0000 + 32'(ld_n);
      if (exp_alu) alu_n++; else ld_n++;
      tick();
      check_cnt++;
      if (rf_write_en !== 1'b1 || rf_write_addr !== exp_addr || rf_write_data !== exp_data)
        $display("FAIL conflict_write c=%0d: got en=%b a=%0d d=%h want 1 %0d %h",
                 c, rf_write_en, rf_write_addr, rf_write_data, exp_addr, exp_data);
      else pass_cnt++;
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    #1;
    check_cnt++;
    if (ld_issue_ready !== 1'b1) $display("FAIL sb_issue_ready: got %b want 1", ld_issue_ready); else pass_cnt++;
    tick();
    rs1_addr = 5'd7; rs2_addr = 5'd8;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_A1A1;
    ld_issue = 1'b1; ld_issue_rd = 5'd7;
    #1;
    check_cnt++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0)
      $display("FAIL sb_busy: got rs1=%b rs2=%b want 1 0", rs1_busy, rs2_busy);
    else pass_cnt++;
    check_cnt++;
    if (alu_ready !== 1'b0 || ld_issue_ready !== 1'b0)
      $display("FAIL sb_stall: got alu_ready=%b issue_ready=%b want 0 0", alu_ready, ld_issue_ready);
    else pass_cnt++;
    tick();
    ld_issue = 1'b0;
    tick();
    check_cnt++;
    if (rf_write_en !== 1'b0 || alu_ready !== 1'b0)
      $display("FAIL sb_stall_hold: got en=%b alu_ready=%b want 0 0", rf_write_en, alu_ready);
    else pass_cnt++;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h10AD_0007;
    #1;
    check_cnt++;
    if (ld_ready !== 1'b1 || alu_ready !== 1'b0)
      $display("FAIL sb_ld_grant: got ld=%b alu=%b want 1 0", ld_ready, alu_ready);
    else pass_cnt++;
    tick();
    ld_valid = 1'b0;
    check_cnt++;
    if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd7 || rf_write_data !== 32'h10AD_0007)
      $display("FAIL sb_ld_write: got en=%b a=%0d d=%h want 1 7 10ad0007", rf_write_en, rf_write_addr, rf_write_data);
    else pass_cnt++;
    #1;
    check_cnt++;
    if (rs1_busy !== 1'b0 || alu_ready !== 1'b1)
      $display("FAIL sb_release: got busy=%b alu_ready=%b want 0 1", rs1_busy, alu_ready);
    else pass_cnt++;
    tick();
    alu_valid = 1'b0;
    check_cnt++;
    if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd7 || rf_write_data !== 32'h0000_A1A1)
      $display("FAIL sb_alu_write: got en=%b a=%0d d=%h want 1 7 0000a1a1", rf_write_en, rf_write_addr, rf_write_data);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_x0();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    #1;
    check_cnt++;
    if (alu_ready !== 1'b1) $display("FAIL x0_alu_ready: got %b want 1", alu_ready); else pass_cnt++;
    tick();
    alu_valid = 1'b0;
    check_cnt++;
    if (rf_write_en !== 1'b0) $display("FAIL x0_wen: got %b want 0", rf_write_en); else pass_cnt++;
    ld_issue = 1'b1; ld_issue_rd = 5'd0;
    #1;
    check_cnt++;
    if (ld_issue_ready !== 1'b1) $display("FAIL x0_issue_ready: got %b want 1", ld_issue_ready); else pass_cnt++;
    tick();
    ld_issue = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    #1;
    check_cnt++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0)
      $display("FAIL x0_busy: got rs1=%b rs2=%b want 0 0", rs1_busy, rs2_busy);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    rs1_addr = 5'd9;
    #1;
    check_cnt++;
    if (rs1_busy !== 1'b0) $display("FAIL same_pre_busy: got %b want 0", rs1_busy); else pass_cnt++;
    $display("note: load return to register 9 with no load outstanding (protocol error, intentional here)");
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_9999;
    ld_issue = 1'b1; ld_issue_rd = 5'd9;
    #1;
    check_cnt++;
    if (ld_ready !== 1'b1 || ld_issue_ready !== 1'b1)
      $display("FAIL same_ready: got ld=%b issue=%b want 1 1", ld_ready, ld_issue_ready);
    else pass_cnt++;
    tick();
    ld_valid = 1'b0; ld_issue = 1'b0;
    check_cnt++;
    if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd9 || rf_write_data !== 32'h0000_9999)
      $display("FAIL same_write: got en=%b a=%0d d=%h want 1 9 00009999", rf_write_en, rf_write_addr, rf_write_data);
    else pass_cnt++;
    #1;
    check_cnt++;
    if (rs1_busy !== 1'b1) $display("FAIL same_set_wins: got %b want 1", rs1_busy); else pass_cnt++;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h0000_0009;
    tick();
    idle_inputs();
    rs1_addr = 5'd9;
    #1;
    check_cnt++;
    if (rs1_busy !== 1'b0) $display("FAIL same_cleanup: got %b want 0", rs1_busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    bit          pend [32];
    int          lost;
    bit          e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          a_v, l_v;
    logic [4:0]  a_rd, l_rd, i_rd, r1, r2;
    logic [31:0] a_d, l_d;
    bit          iss, alu_ok, alu_w, ld_w, iss_ok, b1, b2;
    int          cand [$];
    do_reset();
    foreach (pend[k]) pend[k] = 1'b0;
    lost = 0; e_en = 1'b0; e_addr = '0; e_data = '0;
    a_v = 1'b0; l_v = 1'b0; a_rd = '0; l_rd = '0; a_d = '0; l_d = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      check_cnt++;
      if (rf_write_en !== e_en || (e_en && (rf_write_addr !== e_addr || rf_write_data !== e_data)))
        $display("FAIL rand_write cyc=%0d: got en=%b a=%0d d=%h want %b %0d %h",
                 cyc, rf_write_en, rf_write_addr, rf_write_data, e_en, e_addr, e_data);
      else pass_cnt++;
      if (!a_v && $urandom_range(0, 2) != 0) begin
        a_v = 1'b1; a_rd = 5'($urandom_range(0, 31)); a_d = $urandom;
      end
      if (!l_v && $urandom_range(0, 1) == 1) begin
        cand.delete();
        for (int k = 1; k < 32; k++) if (pend[k]) cand.push_back(k);
        if (cand.size() > 0) begin
          l_v = 1'b1; l_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]); l_d = $urandom;
        end
      end
      iss = ($urandom_range(0, 1) == 1);
      i_rd = 5'($urandom_range(0, 31));
      r1 = 5'($urandom_range(0, 31));
      r2 = 5'($urandom_range(0, 31));
      alu_valid = a_v; alu_rd = a_rd; alu_data = a_d;
      ld_valid = l_v; ld_rd = l_rd; ld_data = l_d;
      ld_issue = iss; ld_issue_rd = i_rd;
      rs1_addr = r1; rs2_addr = r2;
      #1;
      alu_ok = a_v && !pend[a_rd];
      alu_w  = alu_ok && (!l_v || lost >= LIMIT);
      ld_w   = l_v && !alu_w;
      iss_ok = !(i_rd != 0 && pend[i_rd]);
      b1 = (r1 != 0) && pend[r1];
      b2 = (r2 != 0) && pend[r2];
      check_cnt++;
      if (alu_ready !== alu_w || ld_ready !== ld_w)
        $display("FAIL rand_grant cyc=%0d: got alu=%b ld=%b want %b %b", cyc, alu_ready, ld_ready, alu_w, ld_w);
      else pass_cnt++;
      check_cnt++;
      if (ld_issue_ready !== iss_ok || rs1_busy !== b1 || rs2_busy !== b2)
        $display("FAIL rand_sb cyc=%0d: got iss=%b b1=%b b2=%b want %b %b %b",
                 cyc, ld_issue_ready, rs1_busy, rs2_busy, iss_ok, b1, b2);
      else pass_cnt++;
      if (alu_w) begin
        e_en = (a_rd != 0); e_addr = a_rd; e_data = a_d; a_v = 1'b0;
      end else if (ld_w) begin
        e_en = (l_rd != 0); e_addr = l_rd; e_data = l_d; l_v = 1'b0;
      end else begin
        e_en = 1'b0;
      end
      if (alu_ok && !alu_w) lost = (lost < LIMIT) ? lost + 1 : LIMIT;
      else lost = 0;
      if (ld_w) pend[l_rd] = 1'b0;
      if (iss && iss_ok && i_rd != 0) pend[i_rd] = 1'b1;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_alu_only();
    test_conflict();
    test_scoreboard();
    test_x0();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
